e6_timer_core: RTL and testbench
================================

Name: e6_timer_core

Overview:
- Counting engine of the E6 timer peripheral.
- Sits between the S00_AXI register file and the S_AXI_INTR interrupt block.
- Inputs come from the register file: control, load value, prescale and compare.
- Outputs: the live count for read-back, plus single-cycle event pulses that the interrupt block latches into its pending register and drives onto irq.

Parameters:
CNT_WIDTH, 32, counter and load/compare width
PRESC_WIDTH, 16, prescaler divisor width

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
ctrl_en  in  1  run enable (level)
ctrl_autoreload  in  1  1 = periodic, 0 = one-shot
ctrl_up  in  1  1 = count up, 0 = count down; sampled only on load_strobe
load_value  in  CNT_WIDTH  reload / terminal value
load_strobe  in  1  one-cycle pulse from register write; (re)starts counter
prescale  in  PRESC_WIDTH  tick every prescale+1 clocks
compare_value  in  CNT_WIDTH  compare match value
count_out  out  CNT_WIDTH  current count
running  out  1  high in state RUN
tick_out  out  1  one-cycle terminal-count pulse (to interrupt block, intr bit0)
cmp_match_out  out  1  one-cycle compare-match pulse (intr bit1)

Behaviour:
- Reset state:
  - count = 0, psc = 0, dir = down, state = IDLE.
  - count_out = 0, running = 0, tick_out = 0, cmp_match_out = 0.
  - Reset has priority over every other input.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN: ctrl_en = 1.
  - RUN -> IDLE: ctrl_en = 0. Count and psc hold; re-enabling resumes from the held values.
  - RUN -> DONE: terminal count in one-shot mode.
  - DONE -> IDLE: ctrl_en = 0.
  - DONE -> RUN: only via load_strobe while ctrl_en = 1.
- Prescaler:
  - In RUN, psc increments each clock.
  - When psc == prescale, the internal tick_en is asserted and psc returns to 0.
  - prescale = 0 gives tick_en every clock.
  - A change to prescale takes effect immediately. If psc > prescale, psc wraps to 0 on the next clock without asserting tick_en.
- Down mode, on tick_en:
  - count != 0: count - 1.
  - count == 0: terminal. tick_out = 1 in the same cycle the reload appears. Autoreload: count = load_value. One-shot: count stays 0, go to DONE.
- Up mode, on tick_en:
  - count != load_value: count + 1.
  - count == load_value: terminal. Autoreload: count = 0. One-shot: hold, go to DONE.
- load_strobe:
  - Accepted in any state.
  - Sets count = load_value (down) or 0 (up), psc = 0, and dir = ctrl_up.
  - State goes to RUN if ctrl_en = 1, else IDLE.
  - Has priority over a tick_en in the same cycle; that tick is discarded and produces no tick_out.
- cmp_match_out: one-cycle pulse, registered, when a tick_en update makes count equal compare_value. Holding at an equal value produces no repeat pulse.
- Simultaneous terminal and compare match (e.g. compare = reload value): both pulses assert in the same cycle.
- load_value = 0:
  - Down + autoreload: tick_out on every tick_en.
  - Up + autoreload: count stays 0, tick_out on every tick_en.
- Arithmetic wraps modulo 2^CNT_WIDTH. No underflow or overflow is reachable in normal operation.
- Output timing: all outputs are registered; count_out reflects the count after the current edge.
- ARESET mid-run aborts to IDLE with all values zeroed; no pulse is emitted.

Optional Feature:
- Macro: E6_TIMER_CAPTURE_EN.
- When defined, adds three ports:
  - capture_in (in, 1)
  - capture_value (out, CNT_WIDTH; reset 0)
  - capture_out (out, 1; one-cycle pulse)
- capture_in passes through a 2-flop synchroniser, then a rising-edge detector.
  - On a detected edge, capture_value = count_out of that cycle and capture_out pulses.
  - Capture works in every state.
- When not defined: ports absent, no capture logic, and the block's behaviour is otherwise identical.

Test Plan:
- Reset: assert ARESET for 3 cycles with count at 0x55 -> all outputs 0, state IDLE; on release, count holds 0 until load_strobe.
- Down periodic: prescale = 0, load_value = 3, ctrl_autoreload = 1, ctrl_en = 1, load_strobe -> count_out 3,2,1,0,3,2...; tick_out asserts every 4th cycle, coincident with count_out = 3.
- Prescaled one-shot up: prescale = 1, load_value = 2, ctrl_up = 1, ctrl_autoreload = 0 -> count_out steps 0,1,2 every 2 clocks; a single tick_out; running = 0, state DONE; count holds 2 until the next load_strobe.
- Compare and priority:
  - Down, load_value = 5, compare_value = 2: cmp_match_out pulses once per period, when count becomes 2.
  - load_strobe in the same cycle as a terminal tick -> count = 5, no tick_out.
- Pause/resume: drop ctrl_en at count = 7 -> count holds 7 and running = 0 for 10 clocks; re-enable -> next value 6 after prescale+1 clocks.
- With E6_TIMER_CAPTURE_EN: pulse capture_in while count = 0x10 -> capture_value = 0x0E or 0x0F per synchroniser latency (2 clocks of count change at prescale = 0), plus one capture_out pulse.

Source files
------------

// File: rtl/e6_timer_core.sv
// e6_timer_core: counting engine of the E6 timer peripheral.
// A prescaled up/down counter with one-shot or periodic reload. It emits
// single-cycle terminal-count and compare-match pulses for the interrupt block.
// Optional input-capture channel: define E6_TIMER_CAPTURE_EN to build it.
module e6_timer_core #(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   ctrl_en,
  input  logic                   ctrl_autoreload,
  input  logic                   ctrl_up,
  input  logic [CNT_WIDTH-1:0]   load_value,
  input  logic                   load_strobe,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0]   compare_value,
  output logic [CNT_WIDTH-1:0]   count_out,
  output logic                   running,
  output logic                   tick_out,
  output logic                   cmp_match_out
`ifdef E6_TIMER_CAPTURE_EN
  ,
  input  logic                   capture_in,
  output logic [CNT_WIDTH-1:0]   capture_value,
  output logic                   capture_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PSC_ONE = PRESC_WIDTH'(1);

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic [PRESC_WIDTH-1:0] psc_reg, psc_next;
  logic                   dir_up_reg, dir_up_next;
  logic                   tick_reg, tick_next;
  logic                   cmp_reg, cmp_next;
  logic                   tick_en;
  logic                   terminal;
  logic [CNT_WIDTH-1:0]   reload_val;

  // State, counter, prescaler and pulse registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      psc_reg    <= '0;
      dir_up_reg <= 1'b0;
      tick_reg   <= 1'b0;
      cmp_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      psc_reg    <= psc_next;
      dir_up_reg <= dir_up_next;
      tick_reg   <= tick_next;
      cmp_reg    <= cmp_next;
    end
  end

  // Next-state logic: load_strobe wins over any tick in the same cycle
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    psc_next    = psc_reg;
    dir_up_next = dir_up_reg;
    tick_next   = 1'b0;
    cmp_next    = 1'b0;
    tick_en     = 1'b0;
    terminal    = 1'b0;
    reload_val  = dir_up_reg ? '0 : load_value;

    if (load_strobe) begin
      count_next  = ctrl_up ? '0 : load_value;
      psc_next    = '0;
      dir_up_next = ctrl_up;
      state_next  = ctrl_en ? ST_RUN : ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ctrl_en) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!ctrl_en) begin
            // Pause: count and prescaler hold for a later resume
            state_next = ST_IDLE;
          end else begin
            if (psc_reg == prescale) begin
              tick_en  = 1'b1;
              psc_next = '0;
            end else if (psc_reg > prescale) begin
              // Divisor shrank below the running phase: restart silently
              psc_next = '0;
            end else begin
              psc_next = psc_reg + PSC_ONE;
            end

            if (tick_en) begin
              terminal = dir_up_reg ? (count_reg == load_value) : (count_reg == '0);
              if (terminal) begin
                tick_next = 1'b1;
                if (ctrl_autoreload) begin
                  count_next = reload_val;
                  cmp_next   = (reload_val == compare_value);
                end else begin
                  // One-shot: count holds, so no compare update happens
                  state_next = ST_DONE;
                end
              end else begin
                count_next = dir_up_reg ? (count_reg + CNT_ONE) : (count_reg - CNT_ONE);
                cmp_next   = (count_next == compare_value);
              end
            end
          end
        end
        ST_DONE: begin
          if (!ctrl_en) state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign count_out     = count_reg;
  assign running       = (state_reg == ST_RUN);
  assign tick_out      = tick_reg;
  assign cmp_match_out = cmp_reg;

`ifdef E6_TIMER_CAPTURE_EN
  logic                 sync1_reg, sync2_reg, sync3_reg;
  logic [CNT_WIDTH-1:0] capture_value_reg;
  logic                 capture_pulse_reg;

  // Two-flop synchroniser, edge detector and capture register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync1_reg         <= 1'b0;
      sync2_reg         <= 1'b0;
      sync3_reg         <= 1'b0;
      capture_value_reg <= '0;
      capture_pulse_reg <= 1'b0;
    end else begin
      sync1_reg         <= capture_in;
      sync2_reg         <= sync1_reg;
      sync3_reg         <= sync2_reg;
      capture_pulse_reg <= sync2_reg & ~sync3_reg;
      if (sync2_reg & ~sync3_reg) capture_value_reg <= count_reg;
    end
  end

  assign capture_value = capture_value_reg;
  assign capture_out   = capture_pulse_reg;
`endif

endmodule

// File: tb/tb_e6_timer_core.sv
// Self-checking bench for e6_timer_core: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_e6_timer_core;
  localparam int CW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_en, ctrl_autoreload, ctrl_up, load_strobe;
  logic [CW-1:0] load_value, compare_value;
  logic [PW-1:0] prescale;
  logic [CW-1:0] count_out;
  logic          running, tick_out, cmp_match_out;
`ifdef E6_TIMER_CAPTURE_EN
  logic          capture_in;
  logic [CW-1:0] capture_value;
  logic          capture_out;
`endif

  always #5 clk = ~clk;

  e6_timer_core #(.CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .ACLK            (clk),
    .ARESET          (rst),
    .ctrl_en         (ctrl_en),
    .ctrl_autoreload (ctrl_autoreload),
    .ctrl_up         (ctrl_up),
    .load_value      (load_value),
    .load_strobe     (load_strobe),
    .prescale        (prescale),
    .compare_value   (compare_value),
    .count_out       (count_out),
    .running         (running),
    .tick_out        (tick_out),
    .cmp_match_out   (cmp_match_out)
`ifdef E6_TIMER_CAPTURE_EN
    ,
    .capture_in      (capture_in),
    .capture_value   (capture_value),
    .capture_out     (capture_out)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = run, 2 = done
  longint m_count;
  int     m_psc;
  bit     m_up;
  int     m_mode;
  bit     m_tick, m_cmp;
  bit     m_s1, m_s2, m_s3, m_cap_pulse;
  longint m_cap_val;
  localparam longint MOD = 64'd1 << CW;

  task automatic model_tick();
    bit term;
    term = m_up ? (m_count == longint'(load_value)) : (m_count == 0);
    if (term) begin
      m_tick = 1;
      if (ctrl_autoreload) begin
        m_count = m_up ? 0 : longint'(load_value);
        m_cmp   = (m_count == longint'(compare_value));
      end else begin
        m_mode = 2;
      end
    end else begin
      m_count = m_up ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
      m_cmp   = (m_count == longint'(compare_value));
    end
  endtask

  task automatic model_step();
    bit cap_in;
`ifdef E6_TIMER_CAPTURE_EN
    cap_in = capture_in;
`else
    cap_in = 0;
`endif
    m_tick = 0;
    m_cmp  = 0;
    if (rst) begin
      m_count = 0; m_psc = 0; m_up = 0; m_mode = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_cap_pulse = 0; m_cap_val = 0;
      return;
    end
    // capture sees the count as it was during this cycle
    m_cap_pulse = m_s2 && !m_s3;
    if (m_cap_pulse) m_cap_val = m_count;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = cap_in;

    if (load_strobe) begin
      m_count = ctrl_up ? 0 : longint'(load_value);
      m_psc   = 0;
      m_up    = ctrl_up;
      m_mode  = ctrl_en ? 1 : 0;
    end else if (m_mode == 0) begin
      if (ctrl_en) m_mode = 1;
    end else if (m_mode == 2) begin
      if (!ctrl_en) m_mode = 0;
    end else if (!ctrl_en) begin
      m_mode = 0;
    end else if (m_psc > int'(prescale)) begin
      m_psc = 0;
    end else if (m_psc < int'(prescale)) begin
      m_psc++;
    end else begin
      m_psc = 0;
      model_tick();
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("count_out", 64'(count_out), 64'(m_count));
    check_val("running", 64'(running), 64'(m_mode == 1));
    check_val("tick_out", 64'(tick_out), 64'(m_tick));
    check_val("cmp_match_out", 64'(cmp_match_out), 64'(m_cmp));
`ifdef E6_TIMER_CAPTURE_EN
    check_val("capture_value", 64'(capture_value), 64'(m_cap_val));
    check_val("capture_out", 64'(capture_out), 64'(m_cap_pulse));
`endif
  endtask

  task automatic do_load(input bit up, input bit ar, input int lv, input int psc);
    ctrl_up = up; ctrl_autoreload = ar; load_value = CW'(lv); prescale = PW'(psc);
    ctrl_en = 1; load_strobe = 1;
    $display("load up=%0d autoreload=%0d value=%0d prescale=%0d", up, ar, lv, psc);
    cycle();
    load_strobe = 0;
  endtask

  int exp_cnt [9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
  int exp_tk  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  int n;
  bit hit;

  initial begin
    rst = 1; ctrl_en = 0; ctrl_autoreload = 0; ctrl_up = 0; load_strobe = 0;
    load_value = '0; compare_value = CW'(1000); prescale = '0;
`ifdef E6_TIMER_CAPTURE_EN
    capture_in = 0;
`endif
    cycle(); cycle();
    rst = 0;

    // Reset with count at 0x55, then hold at 0 while disabled
    load_value = CW'(32'h55); load_strobe = 1; cycle(); load_strobe = 0; cycle();
    check_val("preload_count", 64'(count_out), 64'h55);
    rst = 1; cycle(); cycle(); cycle();
    check_val("reset_count", 64'(count_out), 64'h0);
    check_val("reset_running", 64'(running), 64'h0);
    rst = 0;
    for (int i = 0; i < 3; i++) cycle();
    check_val("post_reset_count", 64'(count_out), 64'h0);

    // Down periodic, load 3, prescale 0
    do_load(0, 1, 3, 0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cycle();
      check_val("down_seq_count", 64'(count_out), 64'(exp_cnt[i]));
      check_val("down_seq_tick", 64'(tick_out), 64'(exp_tk[i]));
    end

    // Prescaled one-shot up to 2
    do_load(1, 0, 2, 1);
    n = 0;
    for (int i = 0; i < 14; i++) begin cycle(); n += int'(tick_out); end
    check_val("oneshot_ticks", 64'(n), 64'd1);
    check_val("oneshot_count", 64'(count_out), 64'd2);
    check_val("oneshot_running", 64'(running), 64'd0);

    // Compare match once per period, down from 5
    compare_value = CW'(2);
    do_load(0, 1, 5, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin cycle(); n += int'(cmp_match_out); end
    check_val("cmp_pulses", 64'(n), 64'd2);

    // load_strobe coinciding with a terminal tick
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cycle(); hit = (m_count == 0); end
    check_val("reach_zero", 64'(hit), 64'd1);
    load_strobe = 1; cycle(); load_strobe = 0;
    check_val("prio_count", 64'(count_out), 64'd5);
    check_val("prio_tick", 64'(tick_out), 64'd0);

    // Pause at 7 and resume
    do_load(0, 1, 9, 2);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cycle(); hit = (m_count == 7); end
    check_val("reach_seven", 64'(hit), 64'd1);
    ctrl_en = 0;
    for (int i = 0; i < 10; i++) cycle();
    check_val("pause_count", 64'(count_out), 64'd7);
    check_val("pause_running", 64'(running), 64'd0);
    ctrl_en = 1;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin cycle(); hit = (count_out == CW'(6)); end
    check_val("resume_to_six", 64'(hit), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) ctrl_en = ~ctrl_en;
      if ($urandom_range(0, 29) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) ctrl_autoreload = ~ctrl_autoreload;
      if ($urandom_range(0, 39) == 0) compare_value = CW'($urandom_range(0, 9));
`ifdef E6_TIMER_CAPTURE_EN
      if ($urandom_range(0, 7) == 0) capture_in = ~capture_in;
`endif
      load_strobe = ($urandom_range(0, 14) == 0);
      if (load_strobe) begin
        ctrl_up    = 1'($urandom_range(0, 1));
        load_value = CW'($urandom_range(0, 9));
        $display("load up=%0d autoreload=%0d value=%0d prescale=%0d en=%0d",
                 ctrl_up, ctrl_autoreload, load_value, prescale, ctrl_en);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
